// File: rtl/vec_add_sequencer.sv
// Command-level sequencer for a two-input, one-output streaming vector adder.
// Issues A/B read and OUT write requests, joins and sums the element streams, then responds.
//
// state  | meaning
// IDLE   | ready for a command
// ISSUE  | presenting the three channel requests until each is accepted
// STREAM | joining A/B element streams and driving their sum
// FLUSH  | waiting for the writer to report committed data
// RESP   | holding the completion response until accepted
module vec_add_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 49,
  parameter int LEN_W  = 32
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              cmd_0_valid,
  output logic              cmd_0_ready,
  input  logic [31:0]       cmd_0_vec_a_addr,
  input  logic [31:0]       cmd_0_vec_b_addr,
  input  logic [31:0]       cmd_0_vec_out_addr,
  input  logic [LEN_W-1:0]  cmd_0_vector_length,

  output logic              resp_0_valid,
  input  logic              resp_0_ready,

  output logic              vec_a_req_valid,
  input  logic              vec_a_req_ready,
  output logic [LEN_W-1:0]  vec_a_req_len,
  output logic [ADDR_W-1:0] vec_a_req_addr_address,

  output logic              vec_b_req_valid,
  input  logic              vec_b_req_ready,
  output logic [LEN_W-1:0]  vec_b_req_len,
  output logic [ADDR_W-1:0] vec_b_req_addr_address,

  output logic              vec_out_req_valid,
  input  logic              vec_out_req_ready,
  output logic [LEN_W-1:0]  vec_out_req_len,
  output logic [ADDR_W-1:0] vec_out_req_addr_address,

  input  logic              vec_a_data_valid,
  output logic              vec_a_data_ready,
  input  logic [DATA_W-1:0] vec_a_data,

  input  logic              vec_b_data_valid,
  output logic              vec_b_data_ready,
  input  logic [DATA_W-1:0] vec_b_data,

  output logic              vec_out_data_valid,
  input  logic              vec_out_data_ready,
  output logic [DATA_W-1:0] vec_out_data,

  input  logic              write_isFlushed_0_0,
  input  logic              vec_a_inProgress,
  input  logic              vec_b_inProgress
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] BYTES_PER_ELEM = LEN_W'(DATA_W / 8);
  localparam logic [LEN_W-1:0] ONE            = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic [31:0]      addr_a, addr_b, addr_out;
  logic [LEN_W-1:0] elem_len, byte_len, elem_cnt;
  logic             done_a, done_b, done_out;

  logic cmd_fire, fire_a, fire_b, fire_out, all_done;
  logic in_stream, join_valid, elem_fire, last_elem;

  // Reader status is informational only; sequencing never depends on it.
  logic unused_in_progress;
  assign unused_in_progress = vec_a_inProgress | vec_b_inProgress;

  assign cmd_0_ready  = (state == IDLE) && !reset;
  assign resp_0_valid = (state == RESP);

  assign vec_a_req_valid   = (state == ISSUE) && !done_a;
  assign vec_b_req_valid   = (state == ISSUE) && !done_b;
  assign vec_out_req_valid = (state == ISSUE) && !done_out;

  assign vec_a_req_len   = byte_len;
  assign vec_b_req_len   = byte_len;
  assign vec_out_req_len = byte_len;

  assign vec_a_req_addr_address   = {{(ADDR_W-32){1'b0}}, addr_a};
  assign vec_b_req_addr_address   = {{(ADDR_W-32){1'b0}}, addr_b};
  assign vec_out_req_addr_address = {{(ADDR_W-32){1'b0}}, addr_out};

  assign cmd_fire = cmd_0_valid && cmd_0_ready;
  assign fire_a   = vec_a_req_valid && vec_a_req_ready;
  assign fire_b   = vec_b_req_valid && vec_b_req_ready;
  assign fire_out = vec_out_req_valid && vec_out_req_ready;
  assign all_done = (done_a || fire_a) && (done_b || fire_b) && (done_out || fire_out);

  // Both inputs are consumed together, so neither stream can run ahead of the other.
  assign in_stream          = (state == STREAM);
  assign join_valid         = vec_a_data_valid && vec_b_data_valid;
  assign vec_out_data_valid = in_stream && join_valid;
  assign vec_a_data_ready   = in_stream && join_valid && vec_out_data_ready;
  assign vec_b_data_ready   = in_stream && join_valid && vec_out_data_ready;
  assign vec_out_data       = vec_a_data + vec_b_data;

  assign elem_fire = vec_a_data_ready;
  assign last_elem = (elem_cnt == elem_len - ONE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (cmd_fire) state_nxt = (cmd_0_vector_length == '0) ? RESP : ISSUE;
      ISSUE:  if (all_done) state_nxt = STREAM;
      STREAM: if (elem_fire && last_elem) state_nxt = FLUSH;
      FLUSH:  if (write_isFlushed_0_0) state_nxt = RESP;
      RESP:   if (resp_0_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_a   <= '0;
      addr_b   <= '0;
      addr_out <= '0;
      elem_len <= '0;
      byte_len <= '0;
      elem_cnt <= '0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      done_out <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_a   <= cmd_0_vec_a_addr;
        addr_b   <= cmd_0_vec_b_addr;
        addr_out <= cmd_0_vec_out_addr;
        elem_len <= cmd_0_vector_length;
        byte_len <= cmd_0_vector_length * BYTES_PER_ELEM;
        elem_cnt <= '0;
        done_a   <= 1'b0;
        done_b   <= 1'b0;
        done_out <= 1'b0;
      end
      if (fire_a)    done_a   <= 1'b1;
      if (fire_b)    done_b   <= 1'b1;
      if (fire_out)  done_out <= 1'b1;
      if (elem_fire) elem_cnt <= elem_cnt + ONE;
    end
  end

endmodule
